dm_bus_arbiter: RTL

Shares the single-port synchronous data memory between the CPU M-stage data port and a secondary word-only master (DMA/debug). It sequences each access, generates byte enables and lane-replicated write data for `sb`/`sh`/`sw`, and flags misaligned or out-of-range CPU accesses. It stalls the CPU while a read is in flight or the port is busy. It returns the raw memory word; sub-word extraction stays in the load-extension stage downstream.

---
 rtl/dm_bus_arbiter_pkg.sv | 23 ++
 rtl/dm_bus_arbiter_be_gen.sv | 41 ++++
 rtl/dm_bus_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/dm_bus_arbiter_pkg.sv
// Shared definitions for the data-memory bus arbiter: access size codes,
// arbiter FSM states, default data-memory limit and an address helper.
package dm_bus_arbiter_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // First byte address that lies outside the data memory.
  localparam logic [31:0] DM_LIMIT_DEFAULT = 32'h0000_3000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CPU_RD = 2'd1,
    ST_DMA_RD = 2'd2
  } state_t;

  // The memory is word addressed on the bus; byte lanes come from mem_be.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/dm_bus_arbiter_be_gen.sv
// dm_be_gen: combinational byte-enable / lane-replication / alignment check
// for CPU stores and loads. Loads get all-zero enables (a read on the bus).
module dm_be_gen
  import dm_bus_arbiter_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic        i_we,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_misalign
);

  // Decode size into lane enables, replicate store data, flag misalignment.
  always_comb begin
    o_be       = 4'b0000;
    o_wdata    = i_wdata;
    o_misalign = 1'b0;
    case (i_size)
      SZ_BYTE: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      SZ_HALF: begin
        o_be       = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata    = {2{i_wdata[15:0]}};
        o_misalign = i_addr_lo[0];
      end
      // SZ_WORD and the reserved code 3 both behave as a word access.
      default: begin
        o_be       = 4'b1111;
        o_misalign = |i_addr_lo;
      end
    endcase
    if (!i_we) begin
      o_be = 4'b0000;
    end
  end

endmodule

// File: rtl/dm_bus_arbiter.sv
// dm_bus_arbiter: shares the single-port data memory between the CPU M-stage
// port and a word-only DMA/debug master. Reads take one extra cycle; writes
// and address errors finish in the grant cycle.
// Build option: DM_ARB_RR_EN selects round-robin arbitration; otherwise the
// CPU has fixed priority and no last-grant state exists.
module dm_bus_arbiter
  import dm_bus_arbiter_pkg::*;
#(
  parameter logic [31:0] DM_LIMIT = DM_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_size,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_stall,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  output logic        cpu_exc,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [31:0] dma_rdata,
  output logic        mem_en,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_t      r_state;
  state_t      w_state_next;

  logic [3:0]  w_cpu_be;
  logic [31:0] w_cpu_wdata;
  logic        w_cpu_misalign;
  logic        w_cpu_err;
  logic        w_cpu_win;
  logic        w_dma_win;

  logic        w_cpu_stall;
  logic        w_cpu_rvalid;
  logic [31:0] w_cpu_rdata;
  logic        w_cpu_exc;
  logic        w_dma_gnt;
  logic        w_dma_rvalid;
  logic [31:0] w_dma_rdata;
  logic        w_mem_en;
  logic [3:0]  w_mem_be;
  logic [31:0] w_mem_addr;
  logic [31:0] w_mem_wdata;

  // DMA is word-only, so its low address bits carry no information.
  logic        w_unused_dma_lo;
  assign w_unused_dma_lo = &{1'b0, dma_addr[1:0]};

  dm_be_gen u_be_gen (
    .i_size     (cpu_size),
    .i_addr_lo  (cpu_addr[1:0]),
    .i_wdata    (cpu_wdata),
    .i_we       (cpu_we),
    .o_be       (w_cpu_be),
    .o_wdata    (w_cpu_wdata),
    .o_misalign (w_cpu_misalign)
  );

  assign w_cpu_err = w_cpu_misalign | (cpu_addr >= DM_LIMIT);

`ifdef DM_ARB_RR_EN
  // 1 when the DMA held the most recent grant; resets to 1 so the CPU wins first.
  logic r_last_dma;

  assign w_cpu_win = cpu_req & (~dma_req | r_last_dma);

  // Remember who was granted last, exception grants included.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_dma <= 1'b1;
    end else if ((r_state == ST_IDLE) && (cpu_req || dma_req)) begin
      r_last_dma <= ~w_cpu_win;
    end
  end
`else
  assign w_cpu_win = cpu_req;
`endif

  assign w_dma_win = dma_req & ~w_cpu_win;

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Grant selection, bus drive and read-return sequencing.
  always_comb begin
    w_state_next = r_state;
    w_cpu_stall  = 1'b0;
    w_cpu_rvalid = 1'b0;
    w_cpu_rdata  = 32'h0;
    w_cpu_exc    = 1'b0;
    w_dma_gnt    = 1'b0;
    w_dma_rvalid = 1'b0;
    w_dma_rdata  = 32'h0;
    w_mem_en     = 1'b0;
    w_mem_be     = 4'b0000;
    w_mem_addr   = 32'h0;
    w_mem_wdata  = 32'h0;
    case (r_state)
      ST_IDLE: begin
        if (w_cpu_win) begin
          if (w_cpu_err) begin
            // Faulting access is consumed without touching memory.
            w_cpu_exc = 1'b1;
          end else begin
            w_mem_en    = 1'b1;
            w_mem_be    = w_cpu_be;
            w_mem_addr  = word_align(cpu_addr);
            w_mem_wdata = w_cpu_wdata;
            if (!cpu_we) begin
              w_cpu_stall  = 1'b1;
              w_state_next = ST_CPU_RD;
            end
          end
        end else if (w_dma_win) begin
          w_dma_gnt   = 1'b1;
          w_cpu_stall = cpu_req;
          w_mem_en    = 1'b1;
          w_mem_be    = dma_we ? 4'b1111 : 4'b0000;
          w_mem_addr  = word_align(dma_addr);
          w_mem_wdata = dma_wdata;
          if (!dma_we) begin
            w_state_next = ST_DMA_RD;
          end
        end
      end
      ST_CPU_RD: begin
        w_cpu_rvalid = 1'b1;
        w_cpu_rdata  = mem_rdata;
        w_state_next = ST_IDLE;
      end
      ST_DMA_RD: begin
        w_dma_rvalid = 1'b1;
        w_dma_rdata  = mem_rdata;
        w_cpu_stall  = cpu_req;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Outputs are forced low while reset is asserted.
  assign cpu_stall  = reset_n & w_cpu_stall;
  assign cpu_rvalid = reset_n & w_cpu_rvalid;
  assign cpu_rdata  = reset_n ? w_cpu_rdata : 32'h0;
  assign cpu_exc    = reset_n & w_cpu_exc;
  assign dma_gnt    = reset_n & w_dma_gnt;
  assign dma_rvalid = reset_n & w_dma_rvalid;
  assign dma_rdata  = reset_n ? w_dma_rdata : 32'h0;
  assign mem_en     = reset_n & w_mem_en;
  assign mem_be     = reset_n ? w_mem_be : 4'b0000;
  assign mem_addr   = reset_n ? w_mem_addr : 32'h0;
  assign mem_wdata  = reset_n ? w_mem_wdata : 32'h0;

endmodule
